uart_rx: RTL and testbench

Asynchronous serial receiver, 8N1, LSB first. It is the receive-side counterpart of the team's serial transmitter: it recovers bytes from the `rx` line, then presents each byte with a one-cycle strobe. It uses the same `BAUDRATE` divisor macros from `baudgen.vh`, so any tx/rx pair built at the same setting interoperates. Start-bit glitches are filtered and stop-bit violations are flagged.

---
 rtl/uart_rx_if.sv | 11 +
 rtl/uart_rx.sv | 93 +++++++++
 tb/tb_uart_rx.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line and received-byte bundle for uart_rx
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       rcv;
  logic       ferr;
  logic       busy;

  modport master (output rx, input data, rcv, ferr, busy);
  modport slave  (input rx, output data, rcv, ferr, busy);
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 LSB-first serial receiver with start-glitch filter and framing-error strobe
`ifndef B9600
`define B9600 1250
`endif

module uart_rx #(
  parameter int BAUDRATE = `B9600
) (
  input  logic     clk,
  input  logic     rstn,
  uart_rx_if.slave bus
);
  localparam int W = $clog2(BAUDRATE);
  localparam logic [W-1:0] FULL = W'(BAUDRATE - 1);
  localparam logic [W-1:0] HALF = W'(BAUDRATE / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE, FERR} state_t;

  state_t       state;
  state_t       state_next;
  logic         rx_m;
  logic         rx_s;
  logic [W-1:0] divcnt;
  logic         tick;
  logic         reload;
  logic [7:0]   shifter;
  logic [7:0]   data_q;
  logic [3:0]   bitc;
  logic         ferr_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= bus.rx;
      rx_s <= rx_m;
    end
  end

  assign tick = (divcnt == '0);

  always_comb begin
    state_next = state;
    reload     = 1'b0;
    case (state)
      IDLE:  if (!rx_s) state_next = START;
      START: if (tick) state_next = rx_s ? IDLE : DATA;
      DATA: begin
        if (tick) begin
          reload = 1'b1;
          if (bitc == 4'd7) state_next = STOP;
        end
      end
      STOP:  if (tick) state_next = rx_s ? DONE : FERR;
      DONE:  state_next = IDLE;
      // hold here while the line stays low so a break cannot look like a new start bit
      FERR:  if (rx_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      divcnt  <= FULL;
      shifter <= 8'h00;
      bitc    <= 4'd0;
      data_q  <= 8'h00;
      ferr_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next != state || reload) begin
        divcnt <= (state_next == START) ? HALF : FULL;
      end else if (!tick) begin
        divcnt <= divcnt - 1'b1;
      end
      if (state == START && state_next == DATA) begin
        bitc <= 4'd0;
      end else if (state == DATA && tick) begin
        bitc    <= bitc + 4'd1;
        shifter <= {rx_s, shifter[7:1]};
      end
      if (state == STOP && state_next == DONE) data_q <= shifter;
      ferr_q <= (state == STOP && state_next == FERR);
    end
  end

  assign bus.data = data_q;
  assign bus.rcv  = (state == DONE);
  assign bus.ferr = ferr_q;
  assign bus.busy = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - frame-level self-checking bench for uart_rx
module tb_uart_rx;
  localparam int B = 16;

  typedef struct {
    logic [7:0] d;
    int         period;
    int         gap;
    int         exp_rcv;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  uart_rx_if bus ();
  uart_rx #(.BAUDRATE(B)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int rcv_cnt = 0;
  int ferr_cnt = 0;
  int both_cnt = 0;
  int wide_cnt = 0;
  int last_rcv_cyc = 0;
  logic prev_rcv = 1'b0;
  logic prev_ferr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.rcv === 1'b1) begin
      rcv_cnt++;
      last_rcv_cyc = cyc;
    end
    if (bus.ferr === 1'b1) ferr_cnt++;
    if (bus.rcv === 1'b1 && bus.ferr === 1'b1) both_cnt++;
    if ((bus.rcv === 1'b1 && prev_rcv) || (bus.ferr === 1'b1 && prev_ferr)) wide_cnt++;
    prev_rcv  = (bus.rcv === 1'b1);
    prev_ferr = (bus.ferr === 1'b1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input int period, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.rx = bits[i];
      repeat (period) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    bus.rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_not_busy(input int budget);
    for (int n = 0; n < budget && bus.busy === 1'b1; n++) @(negedge clk);
  endtask

  vec_t vt[6];
  int   rc_at[6];
  logic [7:0] last_good;
  int r0, f0, fall;

  initial begin
    vt[0] = '{8'hA5, 16, 20, 1, 0, 8'hA5};
    vt[1] = '{8'h00, 16,  0, 1, 0, 8'h00};
    vt[2] = '{8'hFF, 16,  0, 1, 0, 8'hFF};
    vt[3] = '{8'h55, 16, 20, 1, 0, 8'h55};
    vt[4] = '{8'hC3, 17, 20, 1, 0, 8'hC3};
    vt[5] = '{8'hC3, 15, 20, 1, 0, 8'hC3};

    bus.rx = 1'b1;
    rstn   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_data", bus.data, 8'h00);
    check("reset_rcv", bus.rcv, 1'b0);
    check("reset_ferr", bus.ferr, 1'b0);
    check("reset_busy", bus.busy, 1'b0);
    rstn = 1'b1;
    idle(5);

    for (int i = 0; i < 6; i++) begin
      r0   = rcv_cnt;
      f0   = ferr_cnt;
      fall = cyc;
      send_frame(vt[i].d, vt[i].period, 1'b1);
      rc_at[i] = last_rcv_cyc;
      idle(vt[i].gap);
      check($sformatf("vec%0d_rcv", i), rcv_cnt - r0, vt[i].exp_rcv);
      check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vt[i].exp_ferr);
      check($sformatf("vec%0d_data", i), bus.data, vt[i].exp_data);
      if (i == 0) check_range("first_latency", rc_at[0] - fall, 2 + 8 + 9 * B, 2 + 8 + 9 * B + 2);
    end
    check("b2b_spacing_1", rc_at[2] - rc_at[1], 10 * B);
    check("b2b_spacing_2", rc_at[3] - rc_at[2], 10 * B);
    last_good = 8'hC3;

    // start-bit glitch shorter than half a bit
    r0 = rcv_cnt;
    f0 = ferr_cnt;
    bus.rx = 1'b0;
    repeat (4) @(negedge clk);
    bus.rx = 1'b1;
    check("glitch_busy_rise", bus.busy, 1'b1);
    wait_not_busy(16);
    check("glitch_busy_fall", bus.busy, 1'b0);
    idle(5);
    check("glitch_rcv", rcv_cnt - r0, 0);
    check("glitch_ferr", ferr_cnt - f0, 0);
    send_frame(8'h3C, B, 1'b1);
    idle(10);
    check("after_glitch_rcv", rcv_cnt - r0, 1);
    check("after_glitch_data", bus.data, 8'h3C);
    last_good = 8'h3C;

    // framing error followed by a held-low break
    r0 = rcv_cnt;
    f0 = ferr_cnt;
    send_frame(8'h81, B, 1'b0);
    repeat (40) @(negedge clk);
    check("ferr_count", ferr_cnt - f0, 1);
    check("ferr_no_rcv", rcv_cnt - r0, 0);
    check("ferr_data_kept", bus.data, last_good);
    check("ferr_busy_held", bus.busy, 1'b1);
    bus.rx = 1'b1;
    wait_not_busy(8);
    check("ferr_busy_release", bus.busy, 1'b0);
    idle(4);
    send_frame(8'h96, B, 1'b1);
    idle(10);
    check("after_ferr_rcv", rcv_cnt - r0, 1);
    check("after_ferr_data", bus.data, 8'h96);

    // reset in the middle of data bit 3 of 8'hFA (bits 3..7 high, so the tail is idle-like)
    r0 = rcv_cnt;
    f0 = ferr_cnt;
    bus.rx = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus.rx = (8'hFA >> i) & 8'h01;
      repeat (B) @(negedge clk);
    end
    bus.rx = 1'b1;
    repeat (B / 2) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("midreset_busy", bus.busy, 1'b0);
    check("midreset_data", bus.data, 8'h00);
    rstn = 1'b1;
    idle(B / 2 - 1 + 5 * B + 20);
    check("midreset_rcv", rcv_cnt - r0, 0);
    check("midreset_ferr", ferr_cnt - f0, 0);

    // randomized frames against a frame-level expectation
    for (int k = 0; k < 12; k++) begin
      logic [7:0] b;
      logic       ok;
      int         gap;
      b   = 8'($urandom);
      ok  = ($urandom_range(0, 3) != 0);
      gap = $urandom_range(0, 30);
      if (!ok) gap += 5;
      if (ok) last_good = b;
      r0 = rcv_cnt;
      f0 = ferr_cnt;
      send_frame(b, B, ok);
      idle(gap);
      check($sformatf("rand%0d_rcv", k), rcv_cnt - r0, ok ? 1 : 0);
      check($sformatf("rand%0d_ferr", k), ferr_cnt - f0, ok ? 0 : 1);
      check($sformatf("rand%0d_data", k), bus.data, last_good);
    end

    check("rcv_ferr_overlap", both_cnt, 0);
    check("pulse_width", wide_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
